// File: rtl/spi_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_capture_pkg
// Shared definitions for the SPI capture command sequencer:
//   - host command opcodes
//   - controller state encoding
//   - bit positions inside status byte 0, plus a helper that packs it
// -----------------------------------------------------------------------------
package spi_capture_pkg;

   // Host command opcodes (first byte of every SPI transaction)
   localparam logic [7:0] CMD_START      = 8'h01;
   localparam logic [7:0] CMD_STOP       = 8'h02;
   localparam logic [7:0] CMD_STATUS     = 8'h03;
   localparam logic [7:0] CMD_READ       = 8'h04;
   localparam logic [7:0] CMD_SOFT_RESET = 8'h05;
   localparam logic [7:0] CMD_CLR_OVF    = 8'h06;

   typedef enum logic [2:0] {
      IDLE,
      CMD_WAIT,
      CMD_DONE,
      STATUS,
      STREAM
   } ctrl_state_t;

   // Status byte 0 layout; the low nibble is reserved and reads as zero
   localparam int ST_BIT_CAPTURE  = 7;
   localparam int ST_BIT_OVERFLOW = 6;
   localparam int ST_BIT_FULL     = 5;
   localparam int ST_BIT_EMPTY    = 4;

   function automatic logic [7:0] status_byte0(input logic cap,
                                               input logic ovf,
                                               input logic full,
                                               input logic empty);
      logic [7:0] b;
      b                  = '0;
      b[ST_BIT_CAPTURE]  = cap;
      b[ST_BIT_OVERFLOW] = ovf;
      b[ST_BIT_FULL]     = full;
      b[ST_BIT_EMPTY]    = empty;
      return b;
   endfunction

endpackage

// File: rtl/spi_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_capture_ctrl_if
// Byte-level handshake between the SPI slave engine and the command sequencer.
//   cs_active  chip select, synchronized, 1 = transaction in progress
//   rx_valid   one-cycle pulse, rx_data holds a received byte
//   rx_data    received byte
//   tx_ready   one-cycle pulse, slave latched tx_data and wants the next byte
//   tx_data    next byte to shift out (driven by the sequencer)
// Modports:
//   master  the SPI slave engine (originates the byte traffic)
//   slave   the command sequencer
// -----------------------------------------------------------------------------
interface spi_capture_ctrl_if;

   logic       cs_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic [7:0] tx_data;

   modport master (
      output cs_active,
      output rx_valid,
      output rx_data,
      output tx_ready,
      input  tx_data
   );

   modport slave (
      input  cs_active,
      input  rx_valid,
      input  rx_data,
      input  tx_ready,
      output tx_data
   );

endinterface

// File: rtl/spi_capture_ctrl.sv
// -----------------------------------------------------------------------------
// spi_capture_ctrl
// Command sequencer between the byte-level SPI slave and the microphone capture
// path. Decodes the first byte of each transaction as a command, gates I2S
// capture, streams FIFO bytes or a 3-byte status snapshot back to the host,
// pulses a soft reset and tracks a sticky sample-drop overflow flag.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   spi           byte handshake with the SPI slave (slave modport)
//   fifo_rd_en    one-cycle FIFO pop
//   fifo_rd_data  FIFO output, valid the cycle after fifo_rd_en
//   fifo_empty    FIFO empty flag
//   fifo_full     FIFO full flag
//   fifo_count    FIFO fill level (zero-extended / truncated to 16 bits)
//   capture_en    enables I2S sample writes into the FIFO
//   soft_reset    one-cycle pulse resetting the FIFO and I2S path
//   overflow      sticky: capture was enabled while the FIFO was full
// -----------------------------------------------------------------------------
module spi_capture_ctrl
   import spi_capture_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 14,
   parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_capture_ctrl_if.slave      spi,
   output logic                   fifo_rd_en,
   input  logic [7:0]             fifo_rd_data,
   input  logic                   fifo_empty,
   input  logic                   fifo_full,
   input  logic [COUNT_WIDTH-1:0] fifo_count,
   output logic                   capture_en,
   output logic                   soft_reset,
   output logic                   overflow
);

   ctrl_state_t state_q, state_d;

   logic        cs_q;
   logic        capture_en_q, capture_en_d;
   logic        soft_reset_q, soft_reset_d;
   logic        overflow_q,   overflow_d;
   logic        fifo_rd_en_q, fifo_rd_en_d;
   logic        rd_pend_q,    rd_pend_d;     // popped byte arrives this cycle
   logic [7:0]  tx_data_q,    tx_data_d;
   logic [23:0] status_q,     status_d;      // {byte0, count[15:8], count[7:0]}
   logic [1:0]  idx_q,        idx_d;         // next status byte; 3 = exhausted

   logic        cs_rise;
   logic        cmd_fire;
   logic [15:0] count16;

   // The 16-bit cast zero-extends narrower counts
   assign count16  = 16'(fifo_count);

   assign cs_rise  = spi.cs_active & ~cs_q;
   assign cmd_fire = (state_q == CMD_WAIT) & spi.cs_active & spi.rx_valid;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic; a dropped chip select wins over everything
   // ---------------------------------------------------------------------------
   // NOTE: each combinational output gets a default before any branch so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      if (!spi.cs_active) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:     if (cs_rise) state_d = CMD_WAIT;
            CMD_WAIT: begin
               if (spi.rx_valid) begin
                  case (spi.rx_data)
                     CMD_STATUS: state_d = STATUS;
                     CMD_READ:   state_d = STREAM;
                     default:    state_d = CMD_DONE;
                  endcase
               end
            end
            CMD_DONE, STATUS, STREAM: state_d = state_q;
            default:  state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output / datapath next values
   // ---------------------------------------------------------------------------
   always_comb begin
      logic ovf_clr;

      capture_en_d = capture_en_q;
      soft_reset_d = 1'b0;
      ovf_clr      = 1'b0;
      status_d     = status_q;
      idx_d        = idx_q;
      tx_data_d    = tx_data_q;
      rd_pend_d    = fifo_rd_en_q;

      // Command decode: effects land on the edge after rx_valid
      if (cmd_fire) begin
         case (spi.rx_data)
            CMD_START:      capture_en_d = 1'b1;
            CMD_STOP:       capture_en_d = 1'b0;
            CMD_STATUS: begin
               status_d = {status_byte0(capture_en_q, overflow_q, fifo_full, fifo_empty),
                           count16};
               idx_d    = 2'd0;
            end
            CMD_SOFT_RESET: begin
               capture_en_d = 1'b0;
               soft_reset_d = 1'b1;
               ovf_clr      = 1'b1;
            end
            CMD_CLR_OVF:    ovf_clr = 1'b1;
            default:        ;
         endcase
      end

      // Set beats clear, so a CLR_OVF while still overflowing keeps the flag
      overflow_d = (capture_en_q & fifo_full) | (overflow_q & ~ovf_clr);

      // Pops only from STREAM with the transaction still open
      fifo_rd_en_d = (state_q == STREAM) & spi.cs_active & spi.tx_ready & ~fifo_empty;

      // tx_ready is serviced against the current (pre-decode) state. A byte
      // already in flight from the FIFO always lands, even after CS drops.
      if (rd_pend_q) begin
         tx_data_d = fifo_rd_data;
      end else if (spi.tx_ready) begin
         case (state_q)
            STATUS: begin
               case (idx_q)
                  2'd0:    tx_data_d = status_q[23:16];
                  2'd1:    tx_data_d = status_q[15:8];
                  2'd2:    tx_data_d = status_q[7:0];
                  default: tx_data_d = IDLE_BYTE;
               endcase
               if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
            end
            STREAM: begin
               // With a pop issued, tx_data is loaded when the FIFO answers
               if (!fifo_rd_en_d) tx_data_d = IDLE_BYTE;
            end
            default: tx_data_d = IDLE_BYTE;
         endcase
      end else if (state_q == IDLE) begin
         tx_data_d = IDLE_BYTE;
      end
   end

   // ---------------------------------------------------------------------------
   // Output / datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: the status snapshot and byte index are reset along with the control
   // flops; they are tiny and a defined value keeps a stray STATUS read clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         // cs_q starts high so a transaction already open during reset is not
         // mistaken for a new one; CS must fall and rise again.
         cs_q         <= 1'b1;
         capture_en_q <= 1'b0;
         soft_reset_q <= 1'b0;
         overflow_q   <= 1'b0;
         fifo_rd_en_q <= 1'b0;
         rd_pend_q    <= 1'b0;
         tx_data_q    <= IDLE_BYTE;
         status_q     <= '0;
         idx_q        <= 2'd3;
      end else begin
         cs_q         <= spi.cs_active;
         capture_en_q <= capture_en_d;
         soft_reset_q <= soft_reset_d;
         overflow_q   <= overflow_d;
         fifo_rd_en_q <= fifo_rd_en_d;
         rd_pend_q    <= rd_pend_d;
         tx_data_q    <= tx_data_d;
         status_q     <= status_d;
         idx_q        <= idx_d;
      end
   end

   assign spi.tx_data = tx_data_q;
   assign fifo_rd_en  = fifo_rd_en_q;
   assign capture_en  = capture_en_q;
   assign soft_reset  = soft_reset_q;
   assign overflow    = overflow_q;

endmodule
